// File: rtl/crack_pkg.sv
// Shared types and helpers for the RC4 crack scheduler.
// No logic of its own; no timing.
// No flow control.
package crack_pkg;

   localparam int KEY_W     = 24;
   localparam int CT_AW     = 8;
   localparam int MAX_CORES = 32;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      RUN    = 2'd2,
      DRAIN  = 2'd3
   } sched_state_t;

   // Index of the lowest set bit; 0 when the mask is empty.
   function automatic int first_one(input logic [MAX_CORES-1:0] mask);
      first_one = 0;
      for (int i = MAX_CORES - 1; i >= 0; i--) begin
         if (mask[i]) first_one = i;
      end
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered search pointer.
// Grant in the same cycle as the request; the pointer moves one past the winner.
// A requester that is not granted just keeps its request up.
module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic          gnt_any,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr_q;

   // Search from the pointer upwards first, then wrap around to index 0.
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < N; i++) begin
         if (!gnt_any && req[i] && (i >= int'(ptr_q))) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!gnt_any && req[i]) begin
            gnt_any = 1'b1;
            gnt_idx = IW'(i);
         end
      end
      gnt = gnt_any ? (N'(1) << gnt_idx) : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= '0;
      end else if (gnt_any) begin
         ptr_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

endmodule

// File: rtl/crack_scheduler.sv
// Launches NUM_CORES crack cores over interleaved key slices, keeps the first found key, aborts the rest.
// core_en no earlier than the cycle after en; key_valid the cycle after a found done; ct grant is combinational.
// en is ignored while rdy=0; cores are launched only when they report core_rdy.
module crack_scheduler #(
   parameter int NUM_CORES = 2,
   parameter int KEY_W     = crack_pkg::KEY_W,
   parameter int CT_AW     = crack_pkg::CT_AW
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       en,
   output logic                       rdy,
   output logic [KEY_W-1:0]           key,
   output logic                       key_valid,
   input  logic [NUM_CORES-1:0]       core_rdy,
   output logic [NUM_CORES-1:0]       core_en,
   output logic [NUM_CORES*KEY_W-1:0] core_start_key,
   output logic [NUM_CORES-1:0]       core_abort,
   input  logic [NUM_CORES-1:0]       core_done,
   input  logic [NUM_CORES-1:0]       core_found,
   input  logic [NUM_CORES*KEY_W-1:0] core_key,
   input  logic [NUM_CORES-1:0]       core_ct_req,
   input  logic [NUM_CORES*CT_AW-1:0] core_ct_addr,
   output logic [NUM_CORES-1:0]       core_ct_gnt,
   output logic [CT_AW-1:0]           ct_addr
);

   import crack_pkg::*;

   localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   sched_state_t            state_q, state_d;
   logic [NUM_CORES-1:0]    launched_q, launched_d;
   logic [NUM_CORES-1:0]    finished_q, finished_d;
   logic [KEY_W-1:0]        key_q, key_d;
   logic                    key_valid_q, key_valid_d;
   logic [NUM_CORES-1:0]    fin_now;
   logic [NUM_CORES-1:0]    found_v;
   logic [NUM_CORES-1:0]    abort_v;
   logic [NUM_CORES-1:0]    launch_v;
   logic [IW-1:0]           win_idx;
   logic [KEY_W-1:0]        core_key_a  [NUM_CORES];
   logic [CT_AW-1:0]        core_addr_a [NUM_CORES];
   logic                    gnt_any;
   logic [IW-1:0]           gnt_idx;
   logic [CT_AW-1:0]        last_addr_q;

   // Core i starts its slice at key i; the core itself applies the stride.
   for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
      assign core_start_key[i*KEY_W +: KEY_W] = KEY_W'(i);
      assign core_key_a[i]  = core_key[i*KEY_W +: KEY_W];
      assign core_addr_a[i] = core_ct_addr[i*CT_AW +: CT_AW];
   end

   assign found_v = core_done & core_found;
   assign fin_now = finished_q | core_done;
   assign win_idx = IW'(first_one(MAX_CORES'(found_v)));

   always_comb begin
      state_d     = state_q;
      launched_d  = launched_q;
      finished_d  = finished_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      abort_v     = '0;
      launch_v    = '0;
      case (state_q)
         IDLE: begin
            if (en) begin
               state_d     = LAUNCH;
               launched_d  = '0;
               finished_d  = '0;
               key_valid_d = 1'b0;
            end
         end
         LAUNCH, RUN: begin
            finished_d = fin_now;
            if (|found_v) begin
               // A find stops launching; only cores already running need an abort.
               key_d       = core_key_a[win_idx];
               key_valid_d = 1'b1;
               abort_v     = launched_q & ~fin_now;
               state_d     = (|abort_v) ? DRAIN : IDLE;
            end else begin
               if (state_q == LAUNCH) begin
                  launch_v   = ~launched_q & core_rdy;
                  launched_d = launched_q | launch_v;
                  if (&launched_d) state_d = RUN;
               end
               if ((&launched_d) && (&fin_now)) state_d = IDLE;
            end
         end
         DRAIN: begin
            finished_d = fin_now;
            if (&(fin_now | ~launched_q)) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         launched_q  <= '0;
         finished_q  <= '0;
         key_q       <= '0;
         key_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         launched_q  <= launched_d;
         finished_q  <= finished_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
      end
   end

   assign rdy        = (state_q == IDLE);
   assign key        = key_q;
   assign key_valid  = key_valid_q;
   assign core_en    = launch_v;
   assign core_abort = abort_v;

   rr_arbiter #(.N(NUM_CORES), .IW(IW)) u_ct_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (core_ct_req),
      .gnt     (core_ct_gnt),
      .gnt_any (gnt_any),
      .gnt_idx (gnt_idx)
   );

   // The RAM address stays on the last granted address when nobody is granted.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_addr_q <= '0;
      end else if (gnt_any) begin
         last_addr_q <= core_addr_a[gnt_idx];
      end
   end

   assign ct_addr = gnt_any ? core_addr_a[gnt_idx] : last_addr_q;

endmodule
